regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V core. It is the successor to the 2-read/1-write REG block.
- Configurable width, depth, read-port count and write-port count.
- x0 hardwired to zero.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so decode can detect RAW hazards against in-flight producers.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 39 +++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Architectural x0: reads as zero, never written, never busy.
  localparam int unsigned REG_ZERO = 0;

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/issue bus of the multi-port register file
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD-1:0][AW-1:0]   read_reg;
  logic [NUM_RD-1:0][XLEN-1:0] read_data;
  logic [NUM_RD-1:0]           read_busy;
  logic [NUM_WR-1:0]           RegWrite;
  logic [NUM_WR-1:0][AW-1:0]   write_reg;
  logic [NUM_WR-1:0][XLEN-1:0] write_data;
  logic                        issue_valid;
  logic [AW-1:0]               issue_reg;
  logic                        any_busy;

  // Core side: drives addresses, writebacks and issues.
  modport master (
    output read_reg, RegWrite, write_reg, write_data, issue_valid, issue_reg,
    input  read_data, read_busy, any_busy
  );

  // Register file side.
  modport slave (
    input  read_reg, RegWrite, write_reg, write_data, issue_valid, issue_reg,
    output read_data, read_busy, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits tracking in-flight producers
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_WR = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rsta,
  input  logic                      issue_valid_i,
  input  logic [AW-1:0]             issue_reg_i,
  input  logic [NUM_WR-1:0]         wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0] wr_reg_i,
  output logic [NREGS-1:0]          busy_o,
  output logic                      any_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Completing writes clear first, then a new issue sets, so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p]) busy_d[wr_reg_i[p]] = 1'b0;
    end
    if (issue_valid_i) busy_d[issue_reg_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q[NREGS-1:1];

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port integer register file with bypass and scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rsta,
  regfile_mp_if.slave  bus
);

  localparam int AW  = $clog2(NREGS);
  localparam bit BYP = (BYPASS != 0);

  logic [NREGS-1:0][XLEN-1:0]  regs_q;
  logic [NREGS-1:0][XLEN-1:0]  regs_d;
  logic [NUM_WR-1:0]           wr_live;
  logic [NREGS-1:0]            busy;
  logic                        any_busy;
  logic [NUM_RD-1:0][XLEN-1:0] rd_val;
  logic [NUM_RD-1:0]           fwd_hit;

  // A write port is live only when enabled and not aimed at x0.
  always_comb begin
    wr_live = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_live[p] = bus.RegWrite[p] && (bus.write_reg[p] != AW'(REG_ZERO));
    end
  end

  // Next register contents; later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_live[p]) regs_d[bus.write_reg[p]] = bus.write_data[p];
    end
    regs_d[REG_ZERO] = '0;
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk           (clk),
    .rsta          (rsta),
    .issue_valid_i (bus.issue_valid),
    .issue_reg_i   (bus.issue_reg),
    .wr_en_i       (wr_live),
    .wr_reg_i      (bus.write_reg),
    .busy_o        (busy),
    .any_busy_o    (any_busy)
  );

  // Read lookup with forwarding from same-cycle writes, highest write port last.
  always_comb begin
    rd_val  = '0;
    fwd_hit = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = regs_q[bus.read_reg[i]];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_live[p] && (bus.write_reg[p] == bus.read_reg[i])) begin
          fwd_hit[i] = 1'b1;
          if (BYP) rd_val[i] = bus.write_data[p];
        end
      end
    end
  end

  // Outputs are forced to zero while reset is held, including forwarded data.
  always_comb begin
    bus.read_data = '0;
    bus.read_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.read_data[i] = rsta ? rd_val[i] : '0;
      bus.read_busy[i] = rsta && busy[bus.read_reg[i]] && !(BYP && fwd_hit[i]);
    end
  end

  assign bus.any_busy = any_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp with a behavioural model
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NR = 32;
  localparam int RD = 2;
  localparam int WR = 2;

  logic clk;
  logic rsta;

  regfile_mp_if #(.XLEN(32), .NREGS(NR), .NUM_RD(RD), .NUM_WR(WR)) bus1 ();
  regfile_mp_if #(.XLEN(32), .NREGS(NR), .NUM_RD(RD), .NUM_WR(WR)) bus0 ();

  assign bus0.read_reg    = bus1.read_reg;
  assign bus0.RegWrite    = bus1.RegWrite;
  assign bus0.write_reg   = bus1.write_reg;
  assign bus0.write_data  = bus1.write_data;
  assign bus0.issue_valid = bus1.issue_valid;
  assign bus0.issue_reg   = bus1.issue_reg;

  regfile_mp #(.XLEN(32), .NREGS(NR), .NUM_RD(RD), .NUM_WR(WR), .BYPASS(1)) dut1 (
    .clk(clk), .rsta(rsta), .bus(bus1)
  );
  regfile_mp #(.XLEN(32), .NREGS(NR), .NUM_RD(RD), .NUM_WR(WR), .BYPASS(0)) dut0 (
    .clk(clk), .rsta(rsta), .bus(bus0)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [31:0] mreg  [NR];
  bit          mbusy [NR];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: value a read port must see, given current inputs.
  function automatic logic [31:0] exp_data(input int i, input bit byp);
    int a;
    a = int'(bus1.read_reg[i]);
    if (!rsta || a == 0) return 32'h0;
    if (byp) begin
      for (int p = WR - 1; p >= 0; p--)
        if (bus1.RegWrite[p] && int'(bus1.write_reg[p]) == a) return bus1.write_data[p];
    end
    return mreg[a];
  endfunction

  function automatic bit exp_busy(input int i, input bit byp);
    int a;
    bit written;
    a = int'(bus1.read_reg[i]);
    if (!rsta || a == 0) return 1'b0;
    written = 1'b0;
    for (int p = 0; p < WR; p++)
      if (bus1.RegWrite[p] && int'(bus1.write_reg[p]) == a) written = 1'b1;
    return mbusy[a] && !(byp && written);
  endfunction

  function automatic bit exp_any();
    bit r;
    r = 1'b0;
    for (int k = 1; k < NR; k++) r |= mbusy[k];
    return r;
  endfunction

  // Model state update.
  always @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      for (int k = 0; k < NR; k++) begin mreg[k] = 32'h0; mbusy[k] = 1'b0; end
    end else begin
      for (int p = 0; p < WR; p++) begin
        if (bus1.RegWrite[p] && bus1.write_reg[p] != 5'd0) begin
          mreg[bus1.write_reg[p]]  = bus1.write_data[p];
          mbusy[bus1.write_reg[p]] = 1'b0;
        end
      end
      if (bus1.issue_valid && bus1.issue_reg != 5'd0) mbusy[bus1.issue_reg] = 1'b1;
    end
  end

  // Every-cycle compare of both builds against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < RD; i++) begin
        chk($sformatf("b1_data%0d", i), bus1.read_data[i], exp_data(i, 1'b1));
        chk($sformatf("b1_busy%0d", i), 32'(bus1.read_busy[i]), 32'(exp_busy(i, 1'b1)));
        chk($sformatf("b0_data%0d", i), bus0.read_data[i], exp_data(i, 1'b0));
        chk($sformatf("b0_busy%0d", i), 32'(bus0.read_busy[i]), 32'(exp_busy(i, 1'b0)));
      end
      chk("b1_any", 32'(bus1.any_busy), 32'(exp_any()));
      chk("b0_any", 32'(bus0.any_busy), 32'(exp_any()));
    end
  end

  task automatic idle();
    bus1.read_reg    = '0;
    bus1.RegWrite    = '0;
    bus1.write_reg   = '0;
    bus1.write_data  = '0;
    bus1.issue_valid = 1'b0;
    bus1.issue_reg   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int r, input logic [31:0] d);
    bus1.RegWrite[p]   = 1'b1;
    bus1.write_reg[p]  = 5'(r);
    bus1.write_data[p] = d;
  endtask

  task automatic rd(input int r0, input int r1);
    bus1.read_reg[0] = 5'(r0);
    bus1.read_reg[1] = 5'(r1);
  endtask

  task automatic iss(input int r);
    bus1.issue_valid = 1'b1;
    bus1.issue_reg   = 5'(r);
  endtask

  initial begin
    rsta = 1'b0;
    idle();
    cyc(); cyc();
    rsta = 1'b1;
    chk_en = 1'b1;

    // Reset pulse between edges clears contents and busy immediately.
    wr(0, 1, 32'h1234); iss(31);
    cyc(); idle();
    rd(1, 31);
    #2 rsta = 1'b0;
    #1;
    chk("rst_d0", bus1.read_data[0], 32'h0);
    chk("rst_d1", bus1.read_data[1], 32'h0);
    chk("rst_any", 32'(bus1.any_busy), 32'h0);
    rsta = 1'b1;
    cyc();

    // Dual write then read.
    wr(0, 1, 32'hFF); wr(1, 2, 32'hAA);
    cyc(); idle();
    rd(1, 2);
    #1;
    chk("rd_r1", bus1.read_data[0], 32'hFF);
    chk("rd_r2", bus1.read_data[1], 32'hAA);
    chk("model_r1", mreg[1], 32'hFF);

    // x0 ignores writes and issues.
    wr(0, 0, 32'hDEADBEEF); iss(0); rd(0, 0);
    cyc(); idle(); rd(0, 0);
    #1;
    chk("x0_data", bus1.read_data[0], 32'h0);
    chk("x0_busy", 32'(bus1.read_busy[0]), 32'h0);
    chk("x0_any", 32'(bus1.any_busy), 32'h0);

    // Bypass and write conflict.
    wr(0, 5, 32'h11); rd(5, 5);
    #1;
    chk("byp1_r5", bus1.read_data[0], 32'h11);
    chk("byp0_r5", bus0.read_data[0], 32'h0);
    wr(1, 5, 32'h22);
    #1;
    chk("conf1_byp", bus1.read_data[0], 32'h22);
    chk("conf0_old", bus0.read_data[0], 32'h0);
    cyc(); idle(); rd(5, 5);
    #1;
    chk("conf1_st", bus1.read_data[1], 32'h22);
    chk("conf0_st", bus0.read_data[1], 32'h22);

    // Scoreboard issue, forwarded completion, clear.
    iss(7);
    cyc(); idle(); rd(7, 7);
    #1;
    chk("sb_busy", 32'(bus1.read_busy[0]), 32'h1);
    chk("sb_any", 32'(bus1.any_busy), 32'h1);
    wr(0, 7, 32'h33);
    #1;
    chk("sb_fwd_busy", 32'(bus1.read_busy[0]), 32'h0);
    chk("sb_fwd_data", bus1.read_data[0], 32'h33);
    chk("sb_nobyp_busy", 32'(bus0.read_busy[0]), 32'h1);
    cyc(); idle(); rd(7, 7);
    #1;
    chk("sb_clr_busy", 32'(bus0.read_busy[0]), 32'h0);
    chk("sb_clr_any", 32'(bus1.any_busy), 32'h0);

    // Issue and write to the same register: set wins.
    iss(9);
    cyc(); idle();
    iss(9); wr(0, 9, 32'h44);
    cyc(); idle(); rd(9, 9);
    #1;
    chk("soc_data", bus0.read_data[0], 32'h44);
    chk("soc_busy", 32'(bus0.read_busy[0]), 32'h1);
    chk("model_soc", 32'(mbusy[9]), 32'h1);

    // Async reset while a write is held: nothing lands.
    iss(3);
    cyc(); idle();
    wr(0, 3, 32'h55); rd(3, 9);
    #2 rsta = 1'b0;
    #1;
    chk("arst_d0", bus1.read_data[0], 32'h0);
    chk("arst_d1", bus0.read_data[1], 32'h0);
    chk("arst_busy", 32'(bus1.read_busy[1]), 32'h0);
    chk("arst_any", 32'(bus1.any_busy), 32'h0);
    cyc();
    chk("arst_hold", bus1.read_data[0], 32'h0);
    idle(); rd(3, 9);
    rsta = 1'b1;
    #1;
    chk("arst_r3", bus0.read_data[0], 32'h0);
    chk("arst_r9", bus0.read_data[1], 32'h0);
    cyc();

    // Randomized traffic, narrow address range to provoke conflicts.
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < WR; p++) begin
        bus1.RegWrite[p]   = 1'($urandom_range(0, 1));
        bus1.write_reg[p]  = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        bus1.write_data[p] = $urandom;
      end
      bus1.issue_valid = 1'($urandom_range(0, 1));
      bus1.issue_reg   = 5'($urandom_range(0, 7));
      rd($urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #1 rsta = 1'b0;
        #2 rsta = 1'b1;
      end
      cyc();
    end

    idle();
    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
